dac_spi_tx: RTL and testbench

- Serialises the per-channel output samples (after amplitude/offset scaling) to an external dual 12-bit SPI DAC (MCP4822-style command word).
- Accepts one sample pair per strobe from the waveform datapath and converts signed 16-bit to offset-binary 12-bit.
- Sends channel A then channel B as two CS-framed 16-bit words, then pulses LDAC_n so both DAC outputs update simultaneously.
- Sits between the amp/offset stage and the board DAC pins.

---
 rtl/dac_spi_tx.sv | 156 +++++++++++++++
 tb/tb_dac_spi_tx.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/dac_spi_tx.sv
// dac_spi_tx
//   Serialises one signed 16-bit sample pair to a dual 12-bit SPI DAC
//   (MCP4822-style command word). It sends channel A, then channel B, each as
//   a CS-framed 16-bit word. It then pulses LDAC_n so both outputs update
//   together.
//
//   Ports:
//     s00_axi_aclk / s00_axi_aresetn : clock, async active-low reset
//     sample_a / sample_b            : signed samples, latched on accept
//     enable_a / enable_b            : SHDN_n bit per channel, latched on accept
//     sample_valid / sample_ready    : accept handshake (ready == IDLE)
//     busy                           : sequence in progress
//     overrun                        : 1-cycle pulse, pair dropped while busy
//     dac_cs_n/dac_sclk/dac_sdi      : SPI mode 0, MSB first
//     dac_ldac_n                     : DAC latch strobe
module dac_spi_tx #(
  parameter int CLK_DIV    = 5,
  parameter int CS_GAP     = 4,
  parameter int LDAC_WIDTH = 2
) (
  input  logic        s00_axi_aclk,
  input  logic        s00_axi_aresetn,
  input  logic [15:0] sample_a,
  input  logic [15:0] sample_b,
  input  logic        enable_a,
  input  logic        enable_b,
  input  logic        sample_valid,
  output logic        sample_ready,
  output logic        busy,
  output logic        overrun,
  output logic        dac_cs_n,
  output logic        dac_sclk,
  output logic        dac_sdi,
  output logic        dac_ldac_n
);

  localparam int DW   = $clog2(CLK_DIV + 1);
  localparam int GMAX = (CS_GAP > LDAC_WIDTH) ? CS_GAP : LDAC_WIDTH;
  localparam int CW   = $clog2(GMAX + 1);

  typedef enum logic [2:0] {
    IDLE, SHIFT_A, GAP_A, SHIFT_B, GAP_B, LDAC
  } state_t;

  state_t         state;
  logic [15:0]    sh;
  logic [15:0]    word_b;
  logic [DW-1:0]  div_cnt;
  logic [3:0]     bit_cnt;
  logic [CW-1:0]  cnt;

  // Offset-binary code: flip the sign bit, drop the 4 LSBs (truncate).
  logic [11:0] code_a, code_b;
  logic [15:0] word_a_in, word_b_in;
  logic        unused_lsbs;

  assign code_a      = {~sample_a[15], sample_a[14:4]};
  assign code_b      = {~sample_b[15], sample_b[14:4]};
  // {A/B_n, 0, GA_n=1 (1x gain), SHDN_n, code}
  assign word_a_in   = {1'b0, 1'b0, 1'b1, enable_a, code_a};
  assign word_b_in   = {1'b1, 1'b0, 1'b1, enable_b, code_b};
  assign unused_lsbs = ^{sample_a[3:0], sample_b[3:0]};

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      state        <= IDLE;
      sh           <= '0;
      word_b       <= '0;
      div_cnt      <= '0;
      bit_cnt      <= '0;
      cnt          <= '0;
      sample_ready <= 1'b1;
      busy         <= 1'b0;
      overrun      <= 1'b0;
      dac_cs_n     <= 1'b1;
      dac_sclk     <= 1'b0;
      dac_sdi      <= 1'b0;
      dac_ldac_n   <= 1'b1;
    end else begin
      overrun <= sample_valid && !sample_ready;
      case (state)
        IDLE: begin
          if (sample_valid) begin
            // Both words are built here so later input changes cannot leak in.
            state        <= SHIFT_A;
            sh           <= word_a_in;
            word_b       <= word_b_in;
            dac_cs_n     <= 1'b0;
            dac_sdi      <= word_a_in[15];
            dac_sclk     <= 1'b0;
            div_cnt      <= '0;
            bit_cnt      <= '0;
            sample_ready <= 1'b0;
            busy         <= 1'b1;
          end
        end
        SHIFT_A, SHIFT_B: begin
          if (div_cnt == DW'(CLK_DIV - 1)) begin
            div_cnt <= '0;
            if (!dac_sclk) begin
              dac_sclk <= 1'b1;
            end else begin
              // Falling edge: advance to the next bit, or close the frame.
              dac_sclk <= 1'b0;
              if (bit_cnt == 4'd15) begin
                dac_cs_n <= 1'b1;
                dac_sdi  <= 1'b0;
                cnt      <= '0;
                state    <= (state == SHIFT_A) ? GAP_A : GAP_B;
              end else begin
                bit_cnt <= bit_cnt + 4'd1;
                sh      <= {sh[14:0], 1'b0};
                dac_sdi <= sh[14];
              end
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        GAP_A: begin
          if (cnt == CW'(CS_GAP - 1)) begin
            state    <= SHIFT_B;
            sh       <= word_b;
            dac_sdi  <= word_b[15];
            dac_cs_n <= 1'b0;
            div_cnt  <= '0;
            bit_cnt  <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        GAP_B: begin
          if (cnt == CW'(CS_GAP - 1)) begin
            state      <= LDAC;
            dac_ldac_n <= 1'b0;
            cnt        <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        LDAC: begin
          if (cnt == CW'(LDAC_WIDTH - 1)) begin
            state        <= IDLE;
            dac_ldac_n   <= 1'b1;
            sample_ready <= 1'b1;
            busy         <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dac_spi_tx.sv
// tb_dac_spi_tx
//   Directed bench for dac_spi_tx. dut0 uses default parameters; dut1 uses
//   CLK_DIV=1, CS_GAP=1, LDAC_WIDTH=1. Pins are sampled on the falling clock
//   edge and decoded by a cycle-stepping SPI monitor task.
module tb_dac_spi_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic [15:0] a0, b0, a1, b1;
  logic ea0, eb0, v0, ea1, eb1, v1;
  logic rdy0, bsy0, ovr0, cs0, sclk0, sdi0, ld0;
  logic rdy1, bsy1, ovr1, cs1, sclk1, sdi1, ld1;

  dac_spi_tx dut0 (
    .s00_axi_aclk(clk), .s00_axi_aresetn(rst_n),
    .sample_a(a0), .sample_b(b0), .enable_a(ea0), .enable_b(eb0),
    .sample_valid(v0), .sample_ready(rdy0), .busy(bsy0), .overrun(ovr0),
    .dac_cs_n(cs0), .dac_sclk(sclk0), .dac_sdi(sdi0), .dac_ldac_n(ld0));

  dac_spi_tx #(.CLK_DIV(1), .CS_GAP(1), .LDAC_WIDTH(1)) dut1 (
    .s00_axi_aclk(clk), .s00_axi_aresetn(rst_n),
    .sample_a(a1), .sample_b(b1), .enable_a(ea1), .enable_b(eb1),
    .sample_valid(v1), .sample_ready(rdy1), .busy(bsy1), .overrun(ovr1),
    .dac_cs_n(cs1), .dac_sclk(sclk1), .dac_sdi(sdi1), .dac_ldac_n(ld1));

  int total = 0;
  int bad   = 0;

  // Monitor results of the last capture
  logic [15:0] m_word [4];
  int          m_rise [4];
  int          m_cslen[4];
  int m_nfr, m_gap, m_ldn, m_ldfirst, m_ovr, m_viol, m_total;
  logic m_first_cs;

  task automatic pins(input int w, output logic [6:0] p);
    // {cs_n, sclk, sdi, ldac_n, ready, busy, overrun}
    if (w == 0) p = {cs0, sclk0, sdi0, ld0, rdy0, bsy0, ovr0};
    else        p = {cs1, sclk1, sdi1, ld1, rdy1, bsy1, ovr1};
  endtask

  task automatic drive_valid(input int w, input logic v);
    if (w == 0) v0 = v; else v1 = v;
  endtask

  // Called just after a falling edge. Presents a pair for one cycle, then
  // scrambles the inputs so any late sampling shows up in the words.
  task automatic start(input int w, input logic [15:0] a, input logic [15:0] b,
                       input logic ea, input logic eb);
    if (w == 0) begin a0 = a; b0 = b; ea0 = ea; eb0 = eb; v0 = 1'b1; end
    else        begin a1 = a; b1 = b; ea1 = ea; eb1 = eb; v1 = 1'b1; end
    @(negedge clk);
    if (w == 0) begin a0 = ~a; b0 = ~b; ea0 = ~ea; eb0 = ~eb; v0 = 1'b0; end
    else        begin a1 = ~a; b1 = ~b; ea1 = ~ea; eb1 = ~eb; v1 = 1'b0; end
  endtask

  // Steps one falling edge at a time while ready is low, decoding SPI frames.
  // Optionally pulses sample_valid at step ovr_at.
  task automatic capture(input int w, input int ovr_at, input int budget);
    logic [6:0] p;
    logic cs, sclk, sdi, ld, rdy, bsy, ovr, pcs, psclk;
    int n, idx, gapc;
    n = 0; pcs = 1'b1; psclk = 1'b0; gapc = 0; idx = 0;
    m_nfr = 0; m_gap = -1; m_ldn = 0; m_ldfirst = -1; m_ovr = 0; m_viol = 0;
    m_first_cs = 1'b1;
    for (int i = 0; i < 4; i++) begin m_word[i] = '0; m_rise[i] = 0; m_cslen[i] = 0; end
    pins(w, p);
    {cs, sclk, sdi, ld, rdy, bsy, ovr} = p;
    while (!rdy && n < budget) begin
      if (n == 0) m_first_cs = cs;
      if (!cs) begin
        if (pcs) begin
          if (m_nfr > 0) m_gap = gapc;
          m_nfr++;
          idx = (m_nfr < 4) ? m_nfr - 1 : 3;
          m_word[idx] = '0; m_rise[idx] = 0; m_cslen[idx] = 0;
        end
        m_cslen[idx]++;
        if (sclk && !psclk) begin
          m_word[idx] = {m_word[idx][14:0], sdi};
          m_rise[idx]++;
        end
      end else begin
        gapc = pcs ? gapc + 1 : 1;
        if (sdi || sclk) m_viol++;
      end
      if (!ld) begin
        if (m_ldfirst < 0) m_ldfirst = n;
        m_ldn++;
        if (!cs) m_viol++;
      end
      if (ovr) m_ovr++;
      if (!bsy) m_viol++;
      pcs = cs; psclk = sclk;
      drive_valid(w, n == ovr_at);
      n++;
      @(negedge clk);
      pins(w, p);
      {cs, sclk, sdi, ld, rdy, bsy, ovr} = p;
    end
    drive_valid(w, 1'b0);
    m_total = n;
  endtask

  task automatic test_reset;
    logic [6:0] p;
    int act;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    pins(0, p);
    total++; if (p !== 7'b1001100) begin bad++; $display("FAIL reset_pins0 got=%b exp=%b", p, 7'b1001100); end
    pins(1, p);
    total++; if (p !== 7'b1001100) begin bad++; $display("FAIL reset_pins1 got=%b exp=%b", p, 7'b1001100); end
    rst_n = 1'b1;
    act = 0;
    repeat (50) begin
      @(negedge clk);
      pins(0, p); if (p !== 7'b1001100) act++;
      pins(1, p); if (p !== 7'b1001100) act++;
    end
    total++; if (act !== 0) begin bad++; $display("FAIL reset_idle activity got=%0d exp=0", act); end
  endtask

  task automatic test_single;
    start(0, 16'h0000, 16'h7FFF, 1'b1, 1'b1);
    capture(0, -1, 1000);
    total++; if (m_nfr !== 2) begin bad++; $display("FAIL single frames got=%0d exp=2", m_nfr); end
    total++; if (m_word[0] !== 16'h3800) begin bad++; $display("FAIL single wordA got=%h exp=3800", m_word[0]); end
    total++; if (m_word[1] !== 16'hBFFF) begin bad++; $display("FAIL single wordB got=%h exp=bfff", m_word[1]); end
    total++; if (m_rise[0] !== 16 || m_rise[1] !== 16) begin bad++; $display("FAIL single rises got=%0d/%0d exp=16/16", m_rise[0], m_rise[1]); end
    total++; if (m_cslen[0] !== 160 || m_cslen[1] !== 160) begin bad++; $display("FAIL single cs_low got=%0d/%0d exp=160/160", m_cslen[0], m_cslen[1]); end
    total++; if (m_gap !== 4) begin bad++; $display("FAIL single gap got=%0d exp=4", m_gap); end
    total++; if (m_ldn !== 2) begin bad++; $display("FAIL single ldac_len got=%0d exp=2", m_ldn); end
    total++; if (m_ldfirst !== 328) begin bad++; $display("FAIL single ldac_start got=%0d exp=328", m_ldfirst); end
    total++; if (m_total !== 330) begin bad++; $display("FAIL single seq_len got=%0d exp=330", m_total); end
    total++; if (m_viol !== 0 || m_ovr !== 0) begin bad++; $display("FAIL single protocol viol=%0d ovr=%0d exp=0/0", m_viol, m_ovr); end
  endtask

  task automatic test_convert;
    start(0, 16'h8000, 16'hFFFF, 1'b0, 1'b1);
    capture(0, -1, 1000);
    total++; if (m_word[0] !== 16'h2000) begin bad++; $display("FAIL conv wordA got=%h exp=2000", m_word[0]); end
    total++; if (m_word[1] !== 16'hB7FF) begin bad++; $display("FAIL conv wordB got=%h exp=b7ff", m_word[1]); end
    total++; if (m_total !== 330) begin bad++; $display("FAIL conv seq_len got=%0d exp=330", m_total); end
  endtask

  task automatic test_overrun;
    start(0, 16'h1234, 16'h5678, 1'b1, 1'b1);
    capture(0, 100, 1000);
    total++; if (m_ovr !== 1) begin bad++; $display("FAIL ovr pulse_len got=%0d exp=1", m_ovr); end
    total++; if (m_word[0] !== 16'h3923) begin bad++; $display("FAIL ovr wordA got=%h exp=3923", m_word[0]); end
    total++; if (m_word[1] !== 16'hBD67) begin bad++; $display("FAIL ovr wordB got=%h exp=bd67", m_word[1]); end
    total++; if (m_total !== 330 || m_nfr !== 2) begin bad++; $display("FAIL ovr seq got=%0d/%0d exp=330/2", m_total, m_nfr); end
  endtask

  // Entered on the first ready cycle after test_overrun.
  task automatic test_back_to_back;
    logic [6:0] p;
    int act;
    start(0, 16'h7FFF, 16'h0000, 1'b1, 1'b1);
    capture(0, -1, 1000);
    total++; if (m_first_cs !== 1'b0) begin bad++; $display("FAIL b2b first_cs got=%b exp=0", m_first_cs); end
    total++; if (m_word[0] !== 16'h3FFF || m_word[1] !== 16'hB800) begin bad++; $display("FAIL b2b words got=%h/%h exp=3fff/b800", m_word[0], m_word[1]); end
    total++; if (m_total !== 330) begin bad++; $display("FAIL b2b seq_len got=%0d exp=330", m_total); end
    act = 0;
    repeat (20) begin @(negedge clk); pins(0, p); if (p !== 7'b1001100) act++; end
    total++; if (act !== 0) begin bad++; $display("FAIL b2b idle_after activity got=%0d exp=0", act); end
  endtask

  task automatic test_reset_mid;
    logic [6:0] p;
    int ldlow;
    start(0, 16'h1111, 16'h2222, 1'b1, 1'b1);
    repeat (85) @(negedge clk);
    total++; if (cs0 !== 1'b0) begin bad++; $display("FAIL rstmid in_word cs got=%b exp=0", cs0); end
    rst_n = 1'b0;
    #1;
    pins(0, p);
    total++; if (p !== 7'b1001100) begin bad++; $display("FAIL rstmid instant got=%b exp=%b", p, 7'b1001100); end
    ldlow = 0;
    repeat (5) begin @(negedge clk); if (ld0 !== 1'b1 || cs0 !== 1'b1) ldlow++; end
    rst_n = 1'b1;
    repeat (5) begin @(negedge clk); if (ld0 !== 1'b1 || cs0 !== 1'b1) ldlow++; end
    total++; if (ldlow !== 0) begin bad++; $display("FAIL rstmid no_ldac got=%0d exp=0", ldlow); end
    start(0, 16'h4000, 16'hC000, 1'b1, 1'b1);
    capture(0, -1, 1000);
    total++; if (m_word[0] !== 16'h3C00 || m_word[1] !== 16'hB400) begin bad++; $display("FAIL rstmid words got=%h/%h exp=3c00/b400", m_word[0], m_word[1]); end
    total++; if (m_total !== 330) begin bad++; $display("FAIL rstmid seq_len got=%0d exp=330", m_total); end
  endtask

  task automatic test_sweep;
    start(1, 16'h1234, 16'hEDCB, 1'b1, 1'b0);
    capture(1, -1, 500);
    total++; if (m_word[0] !== 16'h3923 || m_word[1] !== 16'hA6DC) begin bad++; $display("FAIL sweep words got=%h/%h exp=3923/a6dc", m_word[0], m_word[1]); end
    total++; if (m_rise[0] !== 16 || m_rise[1] !== 16) begin bad++; $display("FAIL sweep rises got=%0d/%0d exp=16/16", m_rise[0], m_rise[1]); end
    total++; if (m_cslen[0] !== 32 || m_cslen[1] !== 32) begin bad++; $display("FAIL sweep cs_low got=%0d/%0d exp=32/32", m_cslen[0], m_cslen[1]); end
    total++; if (m_gap !== 1 || m_ldn !== 1) begin bad++; $display("FAIL sweep gap/ldac got=%0d/%0d exp=1/1", m_gap, m_ldn); end
    total++; if (m_total !== 67) begin bad++; $display("FAIL sweep seq_len got=%0d exp=67", m_total); end
    total++; if (m_viol !== 0) begin bad++; $display("FAIL sweep protocol got=%0d exp=0", m_viol); end
  endtask

  initial begin
    rst_n = 1'b0;
    a0 = '0; b0 = '0; ea0 = 1'b0; eb0 = 1'b0; v0 = 1'b0;
    a1 = '0; b1 = '0; ea1 = 1'b0; eb1 = 1'b0; v1 = 1'b0;
    @(negedge clk);
    test_reset;
    test_single;
    test_convert;
    test_overrun;
    test_back_to_back;
    test_reset_mid;
    test_sweep;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
